// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default word width,
// FSM state encodings and the PC reset vector.
package fetch_unit_pkg;

  localparam int WORD_W_DEF = 16;

  localparam logic [15:0] PC_RESET_VEC = 16'h0000;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {word, addr} for the fetch stage.
// flush empties the FIFO and takes priority over push and pop.
// The head entry is presented combinationally on dout.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Storage write; contents need no reset because occ gates validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Drives the PC control strobes, reads the
// synchronous ROM at the PC address and buffers returned words for decode.
// Optional macro FETCH_STALL_CNT_EN adds a saturating stall_cnt output that
// counts RUN cycles where decode was ready but no word was available.
//
// Handshake: a word transfers on any cycle where instr_valid and instr_ready
// are both high; instr_valid never depends combinationally on instr_ready or
// redir_valid, and a presented word is held stable until taken or a redirect.
//
// When the FIFO is empty the word returning from the ROM is forwarded
// straight to decode, so a fresh fetch reaches decode one cycle after issue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] pc_addr,
  output logic [WORD_W-1:0] pc_in,
  output logic              pc_load,
  output logic              pc_inc,
  output logic              pc_reset,
  output logic [WORD_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  input  logic              redir_valid,
  input  logic [WORD_W-1:0] redir_addr,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  state_t              state;
  state_t              state_nxt;
  logic                run;
  logic                inflight;
  logic [WORD_W-1:0]   cap_addr;
  logic [WORD_W-1:0]   last_word;
  logic [WORD_W-1:0]   last_pc;
  logic [2*WORD_W-1:0] fifo_dout;
  logic [OCC_W-1:0]    occ;
  logic [OCC_W:0]      pending;
  logic                fifo_empty;
  logic                deq;
  logic                issue;
  logic                push;
  logic                pop;
  logic                flush;

  assign run        = (state == ST_RUN);
  assign rom_addr   = pc_addr;
  assign fifo_empty = (occ == '0);

  // Words already committed to the buffer after this cycle's dequeue.
  assign pending = {1'b0, occ} + (OCC_W+1)'(inflight) - (OCC_W+1)'(deq);
  assign issue   = run && !redir_valid && (pending < (OCC_W+1)'(DEPTH));

  assign instr_valid = !fifo_empty || inflight;
  assign deq         = instr_valid && instr_ready;
  assign pop         = deq && !fifo_empty;
  assign push        = inflight && !redir_valid && !(fifo_empty && deq);
  assign flush       = run && redir_valid;

  // Head selection: buffered entry, else the returning ROM word, else hold.
  always_comb begin
    if (!fifo_empty) begin
      instr    = fifo_dout[2*WORD_W-1:WORD_W];
      instr_pc = fifo_dout[WORD_W-1:0];
    end else if (inflight) begin
      instr    = rom_data;
      instr_pc = cap_addr;
    end else begin
      instr    = last_word;
      instr_pc = last_pc;
    end
  end

  // State register: BOOT while reset is held, RUN from the first edge after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_BOOT;
    else       state <= state_nxt;
  end

  // Next state and PC control strobes.
  always_comb begin
    state_nxt = state;
    pc_reset  = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_in     = WORD_W'(PC_RESET_VEC);
    case (state)
      ST_BOOT: begin
        pc_reset  = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (redir_valid) begin
          pc_load = 1'b1;
          pc_in   = redir_addr;
        end else begin
          pc_inc = issue;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Outstanding ROM read tracking; a redirect cancels the returning word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      cap_addr <= '0;
    end else begin
      inflight <= issue;
      if (issue) cap_addr <= pc_addr;
    end
  end

  // Last delivered word, shown on instr/instr_pc while nothing is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_word <= '0;
      last_pc   <= '0;
    end else if (deq) begin
      last_word <= instr;
      last_pc   <= instr_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * WORD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({rom_data, cap_addr}),
    .dout  (fifo_dout),
    .occ   (occ)
  );

`ifdef FETCH_STALL_CNT_EN
  // Saturating count of RUN cycles where decode waited on an empty stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (run && instr_ready && !instr_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a behavioural PC and ROM.
// Build with FETCH_STALL_CNT_EN defined to also check stall_cnt.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] pc_addr;
  logic [15:0] pc_in;
  logic        pc_load;
  logic        pc_inc;
  logic        pc_reset;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        redir_valid;
  logic [15:0] redir_addr;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];

  fetch_unit #(
    .DEPTH  (2),
    .WORD_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc_addr),
    .pc_in       (pc_in),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .pc_reset    (pc_reset),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- PC and ROM models ----------------
  initial pc_addr = 16'h1234;
  always @(posedge clk) begin
    if (pc_reset)     pc_addr <= 16'h0000;
    else if (pc_load) pc_addr <= pc_in;
    else if (pc_inc)  pc_addr <= pc_addr + 16'd1;
  end

  initial rom_data = 16'h0000;
  always @(posedge clk) rom_data <= rom_addr ^ 16'hA5A5;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pc", {16'h0, instr_pc}, 32'hDEAD_0000);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", {16'h0, instr_pc}, {16'h0, e});
        check("sb_word", {16'h0, instr}, {16'h0, e ^ 16'hA5A5});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    instr_ready = 1'b1;
    redir_valid = 1'b0;
    redir_addr  = 16'h0000;

    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h0100 + 16'(i));
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);

    // Reset held for 3 cycles.
    repeat (3) step();
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_load",  {31'h0, pc_load},     32'h0);
    check("rst_inc",   {31'h0, pc_inc},      32'h0);
    check("rst_pc_in", {16'h0, pc_in},       32'h0);
    check("rst_pc_reset", {31'h0, pc_reset}, 32'h1);

    // c0: first post-reset cycle, still BOOT.
    reset = 1'b0;
    #1;
    check("c0_pc_reset", {31'h0, pc_reset},    32'h1);
    check("c0_inc",      {31'h0, pc_inc},      32'h0);
    check("c0_valid",    {31'h0, instr_valid}, 32'h0);

    // c1: RUN, PC cleared, first issue.
    step();
    check("c1_pc_reset", {31'h0, pc_reset},    32'h0);
    check("c1_pc",       {16'h0, pc_addr},     32'h0);
    check("c1_inc",      {31'h0, pc_inc},      32'h1);
    check("c1_valid",    {31'h0, instr_valid}, 32'h0);

    // c2..c5: streaming, one word per cycle.
    step();
    check("c2_valid", {31'h0, instr_valid}, 32'h1);
    check("c2_pc",    {16'h0, instr_pc},    32'h0);
    for (int k = 3; k <= 5; k++) begin
      step();
      check("stream_valid", {31'h0, instr_valid}, 32'h1);
      check("stream_pc",    {16'h0, instr_pc},    32'(k - 2));
    end

    // c5: redirect to 0x0100 while head 0x0003 is taken.
    redir_valid = 1'b1;
    redir_addr  = 16'h0100;
    #1;
    check("redir_load",  {31'h0, pc_load}, 32'h1);
    check("redir_pc_in", {16'h0, pc_in},   32'h0100);
    check("redir_inc",   {31'h0, pc_inc},  32'h0);

    // c6: bubble; outputs hold the last delivered word.
    step();
    redir_valid = 1'b0;
    #1;
    check("c6_load",    {31'h0, pc_load},     32'h0);
    check("c6_valid",   {31'h0, instr_valid}, 32'h0);
    check("c6_hold_pc", {16'h0, instr_pc},    32'h3);
    check("c6_pc",      {16'h0, pc_addr},     32'h0100);
    check("c6_inc",     {31'h0, pc_inc},      32'h1);

    // c7: target word arrives.
    step();
    check("c7_valid", {31'h0, instr_valid}, 32'h1);
    check("c7_pc",    {16'h0, instr_pc},    32'h0100);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 32'd2);
`endif

    // c8..c12: backpressure.
    step();
    instr_ready = 1'b0;
    step();
    step();
    check("bp_occ",   {30'h0, dut.occ},  32'h2);
    check("bp_inc",   {31'h0, pc_inc},   32'h0);
    check("bp_pc",    {16'h0, pc_addr},  32'h0103);
    step();
    step();
    check("bp_pc_frozen", {16'h0, pc_addr},     32'h0103);
    check("bp_head",      {16'h0, instr_pc},    32'h0101);
    check("bp_valid",     {31'h0, instr_valid}, 32'h1);

    // c13..c15: release.
    step();
    instr_ready = 1'b1;
    #1;
    check("bp_resume_inc", {31'h0, pc_inc}, 32'h1);
    step();
    step();

    // c16..c18: fill the FIFO again.
    step();
    instr_ready = 1'b0;
    step();
    check("full_occ",  {30'h0, dut.occ},  32'h2);
    check("full_rom",  {16'h0, rom_addr}, 32'h0106);
    check("full_inc",  {31'h0, pc_inc},   32'h0);
    step();

    // c19: redirect with a full FIFO and decode ready.
    step();
    instr_ready = 1'b1;
    redir_valid = 1'b1;
    redir_addr  = 16'hFFFE;
    #1;
    check("fr_head",  {16'h0, instr_pc}, 32'h0104);
    check("fr_load",  {31'h0, pc_load},  32'h1);

    // c20: flushed, fetching the target.
    step();
    redir_valid = 1'b0;
    #1;
    check("fr_flush_occ", {30'h0, dut.occ},     32'h0);
    check("fr_valid",     {31'h0, instr_valid}, 32'h0);
    check("fr_pc",        {16'h0, pc_addr},     32'hFFFE);

    // c21..c23: wrap.
    step();
    check("wrap0", {16'h0, instr_pc}, 32'hFFFE);
    step();
    check("wrap1", {16'h0, instr_pc}, 32'hFFFF);
    step();
    check("wrap2", {16'h0, instr_pc}, 32'h0000);

    // c24: asynchronous reset mid-stream; redirect in BOOT is ignored.
    step();
    instr_ready = 1'b0;
    #1;
    reset       = 1'b1;
    redir_valid = 1'b1;
    #1;
    check("mid_rst_valid",    {31'h0, instr_valid}, 32'h0);
    check("mid_rst_load",     {31'h0, pc_load},     32'h0);
    check("mid_rst_pc_reset", {31'h0, pc_reset},    32'h1);
    check("mid_rst_inc",      {31'h0, pc_inc},      32'h0);
    check("mid_rst_occ",      {30'h0, dut.occ},     32'h0);
`ifdef FETCH_STALL_CNT_EN
    check("mid_rst_stall", stall_cnt, 32'd0);
`endif

    step();
    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
